// File: rtl/axi_rd_arbiter.sv
// Two-requester (IFU/LSU) AXI read-channel arbiter onto one shared memory port.
// Handles one outstanding read at a time: IDLE -> ADDR -> DATA -> IDLE.
module axi_rd_arbiter #(
   parameter int unsigned LSU_PRIO = 0
) (
   input  logic        clock,
   input  logic        reset,
   // IFU
   input  logic [31:0] ifu_araddr_i,
   input  logic        ifu_arvalid_i,
   output logic        ifu_arready_o,
   output logic [31:0] ifu_rdata_o,
   output logic [1:0]  ifu_rresp_o,
   output logic        ifu_rvalid_o,
   input  logic        ifu_rready_i,
   // LSU
   input  logic [31:0] lsu_araddr_i,
   input  logic        lsu_arvalid_i,
   output logic        lsu_arready_o,
   output logic [31:0] lsu_rdata_o,
   output logic [1:0]  lsu_rresp_o,
   output logic        lsu_rvalid_o,
   input  logic        lsu_rready_i,
   // shared memory
   output logic [31:0] m_araddr_o,
   output logic        m_arvalid_o,
   input  logic        m_arready_i,
   input  logic [31:0] m_rdata_i,
   input  logic [1:0]  m_rresp_i,
   input  logic        m_rvalid_i,
   output logic        m_rready_o,
   // status
   output logic [1:0]  grant_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   owner_lsu_q, owner_lsu_d;
   logic   last_lsu_q, last_lsu_d;
   logic   owner_rready_c;

   assign owner_rready_c = owner_lsu_q ? lsu_rready_i : ifu_rready_i;

   // State register; last grant resets to LSU so IFU wins the first tie
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_lsu_q <= 1'b0;
         last_lsu_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         owner_lsu_q <= owner_lsu_d;
         last_lsu_q  <= last_lsu_d;
      end
   end

   // Next-state and arbitration
   always_comb begin
      state_d     = state_q;
      owner_lsu_d = owner_lsu_q;
      last_lsu_d  = last_lsu_q;
      case (state_q)
         IDLE: begin
            if (ifu_arvalid_i || lsu_arvalid_i) begin
               state_d = ADDR;
               if (ifu_arvalid_i && lsu_arvalid_i)
                  owner_lsu_d = (LSU_PRIO != 0) ? 1'b1 : !last_lsu_q;
               else
                  owner_lsu_d = lsu_arvalid_i;
            end
         end
         ADDR: begin
            if (m_arready_i)
               state_d = DATA;
         end
         DATA: begin
            if (m_rvalid_i && owner_rready_c) begin
               state_d     = IDLE;
               owner_lsu_d = 1'b0;
               last_lsu_d  = owner_lsu_q;
            end
         end
         default: begin
            state_d     = IDLE;
            owner_lsu_d = 1'b0;
         end
      endcase
   end

   // Channel steering toward the current owner; everything else held at zero
   always_comb begin
      ifu_arready_o = 1'b0;
      ifu_rdata_o   = 32'h0;
      ifu_rresp_o   = 2'b00;
      ifu_rvalid_o  = 1'b0;
      lsu_arready_o = 1'b0;
      lsu_rdata_o   = 32'h0;
      lsu_rresp_o   = 2'b00;
      lsu_rvalid_o  = 1'b0;
      m_araddr_o    = 32'h0;
      m_arvalid_o   = 1'b0;
      m_rready_o    = 1'b0;
      grant_o       = 2'b00;
      busy_o        = 1'b0;
      case (state_q)
         ADDR: begin
            busy_o      = 1'b1;
            grant_o     = owner_lsu_q ? 2'b10 : 2'b01;
            m_arvalid_o = 1'b1;
            if (owner_lsu_q) begin
               m_araddr_o    = lsu_araddr_i;
               lsu_arready_o = m_arready_i;
            end else begin
               m_araddr_o    = ifu_araddr_i;
               ifu_arready_o = m_arready_i;
            end
         end
         DATA: begin
            busy_o     = 1'b1;
            grant_o    = owner_lsu_q ? 2'b10 : 2'b01;
            m_rready_o = owner_rready_c;
            if (owner_lsu_q) begin
               lsu_rvalid_o = m_rvalid_i;
               lsu_rdata_o  = m_rdata_i;
               lsu_rresp_o  = m_rresp_i;
            end else begin
               ifu_rvalid_o = m_rvalid_i;
               ifu_rdata_o  = m_rdata_i;
               ifu_rresp_o  = m_rresp_i;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: round-robin instance (dut) and LSU-priority
// instance (dut_p) share all stimulus; expectations are hand-derived per cycle.
module tb_axi_rd_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ifu_araddr, lsu_araddr, m_rdata;
   logic        ifu_arvalid, lsu_arvalid, ifu_rready, lsu_rready;
   logic        m_arready, m_rvalid;
   logic [1:0]  m_rresp;

   logic [31:0] ifu_rdata, lsu_rdata, m_araddr, p_ifu_rdata, p_lsu_rdata, p_m_araddr;
   logic [1:0]  ifu_rresp, lsu_rresp, grant, p_ifu_rresp, p_lsu_rresp, p_grant;
   logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, m_arvalid, m_rready, busy;
   logic        p_ifu_arready, p_ifu_rvalid, p_lsu_arready, p_lsu_rvalid, p_m_arvalid, p_m_rready, p_busy;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   axi_rd_arbiter #(.LSU_PRIO(0)) dut (
      .clock(clock), .reset(reset),
      .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready),
      .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp), .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready),
      .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready),
      .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp), .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready),
      .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
      .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
      .grant_o(grant), .busy_o(busy)
   );

   axi_rd_arbiter #(.LSU_PRIO(1)) dut_p (
      .clock(clock), .reset(reset),
      .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(p_ifu_arready),
      .ifu_rdata_o(p_ifu_rdata), .ifu_rresp_o(p_ifu_rresp), .ifu_rvalid_o(p_ifu_rvalid), .ifu_rready_i(ifu_rready),
      .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(p_lsu_arready),
      .lsu_rdata_o(p_lsu_rdata), .lsu_rresp_o(p_lsu_rresp), .lsu_rvalid_o(p_lsu_rvalid), .lsu_rready_i(lsu_rready),
      .m_araddr_o(p_m_araddr), .m_arvalid_o(p_m_arvalid), .m_arready_i(m_arready),
      .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(p_m_rready),
      .grant_o(p_grant), .busy_o(p_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs checked #1..#2 after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      ifu_araddr = '0; lsu_araddr = '0; m_rdata = '0; m_rresp = '0;
      ifu_arvalid = 0; lsu_arvalid = 0; ifu_rready = 0; lsu_rready = 0;
      m_arready = 0; m_rvalid = 0;
      tick(); tick();
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
      chk("rst_m_rready", 32'(m_rready), 32'h0);
      chk("rst_arready", 32'({ifu_arready, lsu_arready}), 32'h0);
      chk("rst_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);

      // IFU-only read
      reset = 1'b1;
      ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; m_arready = 1; ifu_rready = 1;
      #1;
      chk("t0_m_arvalid", 32'(m_arvalid), 32'h0);
      chk("t0_arready", 32'(ifu_arready), 32'h0);
      tick();
      #1;
      chk("t1_m_arvalid", 32'(m_arvalid), 32'h1);
      chk("t1_m_araddr", m_araddr, 32'h3000_0000);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_ifu_arready", 32'(ifu_arready), 32'h1);
      chk("t1_lsu_arready", 32'(lsu_arready), 32'h0);
      tick();
      ifu_arvalid = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t2_ifu_rvalid", 32'(ifu_rvalid), 32'h1);
      chk("t2_ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
      chk("t2_m_rready", 32'(m_rready), 32'h1);
      chk("t2_lsu_rvalid", 32'(lsu_rvalid), 32'h0);
      chk("t2_lsu_rdata", lsu_rdata, 32'h0);
      chk("t2_m_araddr", m_araddr, 32'h0);
      tick();
      m_rvalid = 0;
      #1;
      chk("t3_busy", 32'(busy), 32'h0);
      chk("t3_grant", 32'(grant), 32'h0);

      // Tie from reset: both requesters held continuously
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ifu_arvalid = 1; lsu_arvalid = 1; ifu_araddr = 32'h100; lsu_araddr = 32'h200;
      lsu_rready = 1; m_arready = 1; m_rvalid = 1; m_rdata = 32'h55;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         chk("tie_grant_rr", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("tie_grant_prio", 32'(p_grant), 32'h2);
         chk("tie_araddr_rr", m_araddr, (k % 2 == 0) ? 32'h100 : 32'h200);
         chk("tie_araddr_prio", p_m_araddr, 32'h200);
         chk("tie_spur_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);
         tick();
         #1;
         chk("tie_rvalid_rr", 32'({lsu_rvalid, ifu_rvalid}), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("tie_rvalid_prio", 32'({p_lsu_rvalid, p_ifu_rvalid}), 32'h2);
         tick();
         if (k == 3) begin
            lsu_arvalid = 0; ifu_araddr = 32'h40; m_arready = 0; m_rvalid = 0;
         end
         #1;
         chk("tie_idle_busy", 32'(busy), 32'h0);
      end

      // Address backpressure: 5 stalled cycles then accept
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) m_arready = 1;
         #1;
         chk("bp_m_arvalid", 32'(m_arvalid), 32'h1);
         chk("bp_m_araddr", m_araddr, 32'h40);
         chk("bp_ifu_arready", 32'(ifu_arready), (i == 5) ? 32'h1 : 32'h0);
         tick();
      end

      // Read-data stall: owner rready low for 3 cycles
      ifu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001;
      m_rresp = 2'b10; ifu_rready = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) ifu_rready = 1;
         #1;
         chk("rs_busy", 32'(busy), 32'h1);
         chk("rs_m_rready", 32'(m_rready), (i == 3) ? 32'h1 : 32'h0);
         chk("rs_ifu_rvalid", 32'(ifu_rvalid), 32'h1);
         chk("rs_ifu_rdata", ifu_rdata, 32'hCAFE_0001);
         chk("rs_ifu_rresp", 32'(ifu_rresp), 32'h2);
         tick();
      end

      // Spurious m_rvalid in IDLE and ADDR
      m_rresp = 2'b00; m_rdata = 32'h77;
      #1;
      chk("sp_idle_busy", 32'(busy), 32'h0);
      chk("sp_idle_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);
      chk("sp_idle_m_rready", 32'(m_rready), 32'h0);
      lsu_arvalid = 1; lsu_araddr = 32'h80;
      tick();
      #1;
      chk("sp_addr_grant", 32'(grant), 32'h2);
      chk("sp_addr_m_arvalid", 32'(m_arvalid), 32'h1);
      chk("sp_addr_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);
      chk("sp_addr_m_rready", 32'(m_rready), 32'h0);
      chk("sp_addr_lsu_rdata", lsu_rdata, 32'h0);
      tick();
      m_arready = 1;
      #1;
      chk("sp_addr_held", 32'(busy), 32'h1);
      chk("sp_addr_held_arv", 32'(m_arvalid), 32'h1);
      tick();
      lsu_arvalid = 0; m_arready = 0;
      #1;
      chk("sp_data_lsu_rvalid", 32'(lsu_rvalid), 32'h1);
      chk("sp_data_lsu_rdata", lsu_rdata, 32'h77);
      chk("sp_data_ifu_rdata", ifu_rdata, 32'h0);
      tick();
      m_rvalid = 0;

      // Reset mid-DATA abandons the read
      ifu_arvalid = 1; ifu_araddr = 32'h50; m_arready = 1;
      tick();
      ifu_arvalid = 0;
      tick();
      #1;
      chk("rd_data_busy", 32'(busy), 32'h1);
      reset = 1'b0;
      tick();
      reset = 1'b1; m_rvalid = 1;
      #1;
      chk("rd_busy", 32'(busy), 32'h0);
      chk("rd_grant", 32'(grant), 32'h0);
      chk("rd_m_arvalid", 32'(m_arvalid), 32'h0);
      chk("rd_m_rready", 32'(m_rready), 32'h0);
      chk("rd_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);
      m_rvalid = 0; ifu_arvalid = 1; lsu_arvalid = 1;
      tick();
      #1;
      chk("rd_tie_grant_rr", 32'(grant), 32'h1);
      chk("rd_tie_grant_prio", 32'(p_grant), 32'h2);
      ifu_arvalid = 0; lsu_arvalid = 0;
      tick();
      m_rvalid = 1; m_rdata = 32'h1234_5678;
      #1;
      chk("rd_after_rdata", ifu_rdata, 32'h1234_5678);
      tick();
      #1;
      chk("rd_after_idle", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter LSU_PRIO, default 0: 0 = round-robin on simultaneous requests; 1 = LSU always wins ties.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-low (reset==0 resets state on posedge clock).
REQ-004 SHALL have ports ifu_araddr_i input 32, ifu_arvalid_i input 1, ifu_arready_o output 1  IFU read-address channel.
REQ-005 SHALL have ports ifu_rdata_o output 32, ifu_rresp_o output 2, ifu_rvalid_o output 1, ifu_rready_i input 1  IFU read-data channel.
REQ-006 SHALL have ports lsu_araddr_i input 32, lsu_arvalid_i input 1, lsu_arready_o output 1  LSU read-address channel.
REQ-007 SHALL have ports lsu_rdata_o output 32, lsu_rresp_o output 2, lsu_rvalid_o output 1, lsu_rready_i input 1  LSU read-data channel.
REQ-008 SHALL have ports m_araddr_o output 32, m_arvalid_o output 1, m_arready_i input 1  shared memory address channel.
REQ-009 SHALL have ports m_rdata_i input 32, m_rresp_i input 2, m_rvalid_i input 1, m_rready_o output 1  shared memory data channel.
REQ-010 SHALL have ports grant_o output 2 ({lsu,ifu} one-hot owner, 00 idle) and busy_o output 1 (state != IDLE).

Function
REQ-011 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding read at a time, no pipelining.
REQ-012 IDLE: if any *_arvalid_i, SHALL register owner and go to ADDR next cycle; no output asserted toward memory in IDLE.
REQ-013 Tie (both arvalid in IDLE): LSU_PRIO=1 -> LSU; LSU_PRIO=0 -> requester not granted last (last_grant register).
REQ-014 ADDR: m_arvalid_o=1, m_araddr_o = owner's araddr_i (combinational mux on owner); owner's arready_o = m_arready_i; non-owner arready_o=0.
REQ-015 ADDR: on m_arvalid_o && m_arready_i SHALL go to DATA; otherwise hold ADDR indefinitely (requester holds arvalid/araddr per AXI).
REQ-016 DATA: m_rready_o = owner's rready_i; owner's rvalid_o = m_rvalid_i; owner's rdata_o/rresp_o = m_rdata_i/m_rresp_i; non-owner rvalid_o=0.
REQ-017 DATA: on m_rvalid_i && m_rready_o SHALL go to IDLE, clear owner, set last_grant = owner.
REQ-018 Non-owner rdata_o/rresp_o SHALL be 0; m_araddr_o SHALL be 0 outside ADDR.
REQ-019 Minimum latency: request at cycle t -> m_arvalid_o at t+1 -> (m_arready_i same cycle) DATA at t+2 -> earliest completion t+2; new grant earliest t+3.
REQ-020 A requester deasserting arvalid while IDLE and not yet granted SHALL simply lose the arbitration; once granted (ADDR), arbiter SHALL not re-arbitrate.
REQ-021 m_rvalid_i in IDLE or ADDR SHALL be ignored (m_rready_o=0, no requester rvalid).
REQ-022 grant_o SHALL be 01 (IFU) or 10 (LSU) in ADDR/DATA, 00 in IDLE; never 11.

Reset
REQ-023 On reset==0 at posedge: state=IDLE, owner=none, last_grant=LSU (IFU wins first tie), so all outputs 0: m_arvalid_o, m_rready_o, *_arready_o, *_rvalid_o, grant_o, busy_o.
REQ-024 Reset asserted in ADDR or DATA SHALL abandon the transaction without completing it to the requester; next cycle after release state is IDLE.

Verification
REQ-025 IFU-only read: ifu_arvalid=1, addr 0x30000000, m_arready=1 in ADDR, m_rvalid=1 rdata 0xDEADBEEF next cycle, ifu_rready=1 -> m_araddr=0x30000000 at t+1, ifu_rdata=0xDEADBEEF ifu_rvalid=1 at t+2, IDLE at t+3.
REQ-026 Tie, LSU_PRIO=0, both requests held continuously from reset -> grant order IFU, LSU, IFU, LSU; LSU_PRIO=1 -> LSU, LSU, ... while LSU requests.
REQ-027 Backpressure: m_arready=0 for 5 cycles in ADDR, then 1 -> m_arvalid held 6 cycles with constant address; owner arready pulses only on final cycle.
REQ-028 rready stall: m_rvalid=1, owner rready=0 for 3 cycles -> m_rready_o=0, stays DATA, rdata passed through; completes on cycle rready=1.
REQ-029 Reset mid-DATA: reset=0 for one cycle while DATA -> all outputs 0 next cycle, busy_o=0; subsequent IFU request served normally with IFU winning a tie.
REQ-030 Spurious m_rvalid_i=1 in IDLE and ADDR -> no *_rvalid_o, m_rready_o=0, state unaffected.
